ula_acumulador_param: RTL
=========================

// Module: ula_acumulador_param
// PURPOSE
//  Parametrised successor of the 4-bit accumulator ULA. Decodes {opcode,operando}
//  from the data bus, executes arithmetic/logic/shift ops on a DATA_W accumulator,
//  drives a 2*DATA_W output register and Z/C flags. Multi-cycle shift-add multiply.
//  Sits between the instruction-memory data bus and the LED/display output stage.
// PARAMETERS
//  DATA_W  4  accumulator/operand width; bus = 4+DATA_W bits, regSaida = 2*DATA_W bits
// PORTS
//  Clock            in   1          single clock; all state updates on rising edge
//  Reset            in   1          synchronous, active-high
//  barramentoDados  in   4+DATA_W   [top 4]=opcode, [DATA_W-1:0]=operando
//  RegEnable        in   1          active-low instruction valid
//  Pronto           out  1          1 = ready to accept an instruction
//  opcode           out  4          combinational copy of bus opcode field
//  operando         out  DATA_W     combinational copy of bus operand field
//  regAcumulador    out  DATA_W     accumulator
//  regSaida         out  2*DATA_W   output register
//  SaidaValida      out  1          1-cycle pulse on the edge regSaida is written
//  FlagZero         out  1          accumulator == 0 after last acc-writing op
//  FlagCarry        out  1          carry/borrow/shifted-out bit of last acc-writing op
// BEHAVIOUR
//  - Reset=1 at edge: regAcumulador=0, regSaida=0, flags=0, SaidaValida=0, state=OCIOSO.
//    Reset wins over any instruction, including mid-multiply (multiply aborted, no result).
//  - Pronto = (state==OCIOSO), combinational. Accept = RegEnable==0 && Pronto at edge.
//  - Not accepted while Pronto=0: bus ignored, not queued; producer holds until Pronto=1.
//  - Single-cycle ops take effect at the accept edge; SaidaValida default 0 each cycle.
//  - Opcodes (A=acc, O=operando, results truncated to DATA_W unless noted):
//    0 NOP; 1 LDA A<=O; 2 ADD regSaida<=zext(A+O) (DATA_W+1-bit sum), A/flags unchanged;
//    3 ADDA A<=A+O, C=carry-out; 4 SUB A<=A-O, C=borrow (1 when O>A);
//    5 AND; 6 OR; 7 XOR (A<=A op O, C=0); 8 NOT A<=~A, C=0;
//    9 SHL A<=A<<1, C=old A[MSB]; A SHR A<=A>>1 (logical), C=old A[0];
//    B OUT regSaida<=zext(A); C MUL (see below); D CLR A<=0, Z=1, C=0; E,F NOP.
//  - Z/C update only on acc-writing ops (1,3-A,D); Z computed on the new A value.
//  - ADD, OUT, MUL write regSaida and pulse SaidaValida; flags untouched.
//  - FSM: OCIOSO --accept MUL--> MULT; MULT --cnt==1--> OCIOSO; Reset -> OCIOSO.
//  - MUL at accept edge: mcand<=zext(A), mplier<=O, prod<=0, cnt<=DATA_W.
//    Each MULT edge: if mplier[0] prod+=mcand; mcand<<=1; mplier>>=1; cnt--.
//    On the edge with cnt==1 the final step result goes to regSaida, SaidaValida=1,
//    state->OCIOSO. regSaida valid exactly DATA_W edges after accept; Pronto=1 the
//    following cycle. A unchanged; product full 2*DATA_W, never overflows.
//  - Back-to-back single-cycle instructions accepted every cycle.
// CONFIGURATION
//  ULA_MUL_EN defined: opcode C performs multi-cycle multiply, MULT state present.
//  ULA_MUL_EN undefined: no multiplier datapath/MULT state; opcode C is NOP; Pronto
//  is constant 1 after reset.
// TESTING (DATA_W=4, ULA_MUL_EN defined unless noted)
//  1 Reset; LDA 5; ADD 3 -> regSaida=8'h08, SaidaValida 1 cycle, A=4'h5, Z=0 C=0.
//  2 LDA F; ADDA 1 -> A=4'h0, Z=1, C=1; then SHL on A=9 -> A=4'h2, C=1.
//  3 LDA 3; SUB 5 -> A=4'hE, C=1, Z=0; AND 0 -> A=0, Z=1, C=0.
//  4 LDA D; MUL B -> Pronto=0 for 4 cycles, regSaida=8'h8F after 4th edge,
//    one SaidaValida pulse; ADDA 1 held during busy executes only after Pronto=1.
//  5 MUL in flight, Reset=1 on 2nd MULT edge -> all outputs 0, no SaidaValida,
//    Pronto=1 next cycle.
//  6 ULA_MUL_EN undefined: LDA 7; MUL 2 -> regSaida/A/flags unchanged, Pronto stays 1.

Source files
------------

// File: rtl/ula_acumulador_param.sv
// Parametrised accumulator ULA: decodes {opcode,operando}, updates accumulator, output register and Z/C flags.
// Optional macro ULA_MUL_EN adds the multi-cycle shift-add multiplier (opcode C) and the MULT state.
module ula_acumulador_param #(
  parameter int unsigned DATA_W = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_W+3:0]     barramentoDados,
  input  logic                  RegEnable,
  output logic                  Pronto,
  output logic [3:0]            opcode,
  output logic [DATA_W-1:0]     operando,
  output logic [DATA_W-1:0]     regAcumulador,
  output logic [2*DATA_W-1:0]   regSaida,
  output logic                  SaidaValida,
  output logic                  FlagZero,
  output logic                  FlagCarry
);

  localparam int unsigned OUT_W = 2 * DATA_W;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_ADDA = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hD;

  logic [DATA_W-1:0] acc_nxt;
  logic [OUT_W-1:0]  saida_nxt;
  logic              valid_nxt;
  logic              z_nxt;
  logic              c_nxt;
  logic              acc_wr;
  logic              accept;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   dif_w;

  assign opcode   = barramentoDados[DATA_W+3:DATA_W];
  assign operando = barramentoDados[DATA_W-1:0];
  assign accept   = ~RegEnable & Pronto;

  // Extra top bit of sum/difference is the carry-out / borrow
  assign sum_w = {1'b0, regAcumulador} + {1'b0, operando};
  assign dif_w = {1'b0, regAcumulador} - {1'b0, operando};

`ifdef ULA_MUL_EN
  localparam logic [3:0]  OP_MUL = 4'hC;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic {OCIOSO, MULT} state_e;

  state_e            state, state_nxt;
  logic [OUT_W-1:0]  mcand, mcand_nxt;
  logic [OUT_W-1:0]  prod, prod_nxt, prod_step;
  logic [DATA_W-1:0] mplier, mplier_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  assign Pronto    = (state == OCIOSO);
  assign prod_step = mplier[0] ? (prod + mcand) : prod;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= OCIOSO;
    else       state <= state_nxt;
  end
`else
  assign Pronto = 1'b1;
`endif

  // Next-state and datapath decode
  always_comb begin
    acc_nxt   = regAcumulador;
    saida_nxt = regSaida;
    valid_nxt = 1'b0;
    z_nxt     = FlagZero;
    c_nxt     = FlagCarry;
    acc_wr    = 1'b0;
`ifdef ULA_MUL_EN
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    prod_nxt   = prod;
    cnt_nxt    = cnt;
    if (state == MULT) begin
      prod_nxt   = prod_step;
      mcand_nxt  = {mcand[OUT_W-2:0], 1'b0};
      mplier_nxt = {1'b0, mplier[DATA_W-1:1]};
      cnt_nxt    = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        saida_nxt = prod_step;
        valid_nxt = 1'b1;
        state_nxt = OCIOSO;
      end
    end
`endif
    if (accept) begin
      case (opcode)
        OP_LDA:  begin acc_nxt = operando;                   c_nxt = 1'b0;                      acc_wr = 1'b1; end
        OP_ADD:  begin saida_nxt = OUT_W'(sum_w);            valid_nxt = 1'b1;                                 end
        OP_ADDA: begin acc_nxt = sum_w[DATA_W-1:0];          c_nxt = sum_w[DATA_W];             acc_wr = 1'b1; end
        OP_SUB:  begin acc_nxt = dif_w[DATA_W-1:0];          c_nxt = dif_w[DATA_W];             acc_wr = 1'b1; end
        OP_AND:  begin acc_nxt = regAcumulador & operando;   c_nxt = 1'b0;                      acc_wr = 1'b1; end
        OP_OR:   begin acc_nxt = regAcumulador | operando;   c_nxt = 1'b0;                      acc_wr = 1'b1; end
        OP_XOR:  begin acc_nxt = regAcumulador ^ operando;   c_nxt = 1'b0;                      acc_wr = 1'b1; end
        OP_NOT:  begin acc_nxt = ~regAcumulador;             c_nxt = 1'b0;                      acc_wr = 1'b1; end
        OP_SHL:  begin acc_nxt = {regAcumulador[DATA_W-2:0], 1'b0}; c_nxt = regAcumulador[DATA_W-1]; acc_wr = 1'b1; end
        OP_SHR:  begin acc_nxt = {1'b0, regAcumulador[DATA_W-1:1]}; c_nxt = regAcumulador[0];        acc_wr = 1'b1; end
        OP_OUT:  begin saida_nxt = OUT_W'(regAcumulador);    valid_nxt = 1'b1;                                 end
        OP_CLR:  begin acc_nxt = '0;                         c_nxt = 1'b0;                      acc_wr = 1'b1; end
`ifdef ULA_MUL_EN
        OP_MUL: begin
          mcand_nxt  = OUT_W'(regAcumulador);
          mplier_nxt = operando;
          prod_nxt   = '0;
          cnt_nxt    = CNT_W'(DATA_W);
          state_nxt  = MULT;
        end
`endif
        default: ;
      endcase
      if (acc_wr) z_nxt = (acc_nxt == '0);
    end
  end

  // Datapath registers; reset aborts any multiply in flight
  always_ff @(posedge Clock) begin
    if (Reset) begin
      regAcumulador <= '0;
      regSaida      <= '0;
      SaidaValida   <= 1'b0;
      FlagZero      <= 1'b0;
      FlagCarry     <= 1'b0;
`ifdef ULA_MUL_EN
      mcand         <= '0;
      mplier        <= '0;
      prod          <= '0;
      cnt           <= '0;
`endif
    end else begin
      regAcumulador <= acc_nxt;
      regSaida      <= saida_nxt;
      SaidaValida   <= valid_nxt;
      FlagZero      <= z_nxt;
      FlagCarry     <= c_nxt;
`ifdef ULA_MUL_EN
      mcand         <= mcand_nxt;
      mplier        <= mplier_nxt;
      prod          <= prod_nxt;
      cnt           <= cnt_nxt;
`endif
    end
  end

endmodule
